// File: rtl/mem_pkg.sv
// Shared definitions for the data-side load/store path: funct3 codes, lane masks,
// FSM state encoding and small decode helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Stores only exist as SB/SH/SW; loads reject the three unused encodings.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        if (is_store) begin
            bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the way
// out, byte/half selection with sign or zero extension on the way back.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = BE_BYTE << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = BE_HALF << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_rdata = i_rdata;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store stage: req/gnt/rvalid bus handshake, lane steering, stall and timeout.
// Build option DATA_MEM_CTRL_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cpu_load,
    input  logic              i_cpu_store,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    input  logic [2:0]        i_cpu_funct3,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_stall,
    output logic              o_cpu_done,
    output logic              o_mem_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_start;
    logic              w_illegal;
    logic              w_trap;
    logic [ADDR_W-1:0] w_addr_in;
    logic              w_timeout;
    logic              w_abort;
    logic              w_err_nxt;
    logic              w_in_req;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_lane;
    logic [31:0]       w_rdata_ext;

    assign w_start   = i_cpu_load | i_cpu_store;
    assign w_illegal = f3_illegal(i_cpu_store, i_cpu_funct3);
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_in_req  = (r_state == ST_REQ);

    always_comb begin
        w_addr_in = i_cpu_addr;
`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
        w_trap = f3_misaligned(i_cpu_funct3, i_cpu_addr[1:0]);
`else
        // No trap: drop the offending low bits and carry on as an aligned access.
        w_trap = 1'b0;
        case (i_cpu_funct3[1:0])
            2'b01:   w_addr_in[0]   = 1'b0;
            2'b10:   w_addr_in[1:0] = 2'b00;
            default: ;
        endcase
`endif
    end

    mem_lane_align u_lane (
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_f3),
        .i_wdata   (r_wdata),
        .i_rdata   (i_bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata_lane),
        .o_rdata   (w_rdata_ext)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_illegal || w_trap) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_bus_gnt) begin
                    w_state_nxt = r_we ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                    w_abort     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_bus_rvalid) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                    w_abort     = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_f3    <= 3'b000;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_REQ || r_state == ST_WAIT) ? r_cnt + CNT_W'(1) : '0;
            if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
                r_err <= w_err_nxt;
            end
            if (r_state == ST_IDLE && w_start) begin
                r_addr  <= w_addr_in;
                r_f3    <= i_cpu_funct3;
                r_wdata <= i_cpu_wdata;
                r_we    <= i_cpu_store;
            end
            if (w_abort) begin
                r_rdata <= 32'd0;
            end else if (r_state == ST_WAIT && i_bus_rvalid) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    // Bus qualifiers are only driven while the request is outstanding.
    assign o_bus_req   = w_in_req;
    assign o_bus_we    = w_in_req & r_we;
    assign o_bus_addr  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign o_bus_be    = w_in_req ? w_be : 4'b0000;
    assign o_bus_wdata = w_in_req ? w_wdata_lane : 32'd0;

    assign o_cpu_rdata = r_rdata;
    assign o_cpu_done  = (r_state == ST_DONE);
    assign o_mem_err   = (r_state == ST_DONE) & r_err;
    assign o_cpu_stall = w_start && (r_state != ST_DONE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a short timeout so the abort path is reachable.
module tb_data_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_load, cpu_store;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_done, mem_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_ctrl #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_cpu_load   (cpu_load),
        .i_cpu_store  (cpu_store),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_funct3 (cpu_funct3),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_stall  (cpu_stall),
        .o_cpu_done   (cpu_done),
        .o_mem_err    (mem_err),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_be     (bus_be),
        .o_bus_wdata  (bus_wdata),
        .i_bus_gnt    (bus_gnt),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // IDLE -> REQ (gnt at once) -> DONE
    task automatic run_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        cpu_store = 1'b1; cpu_addr = a; cpu_funct3 = f3; cpu_wdata = wd;
        #1;
        check_val({tag, "_stall1"}, cpu_stall, 1);
        check_val({tag, "_noreq1"}, bus_req, 0);
        step();
        bus_gnt = 1'b1;
        #1;
        check_val({tag, "_req"},   bus_req, 1);
        check_val({tag, "_we"},    bus_we, 1);
        check_val({tag, "_addr"},  bus_addr, exp_addr);
        check_val({tag, "_be"},    bus_be, exp_be);
        check_val({tag, "_wdata"}, bus_wdata, exp_wd);
        check_val({tag, "_stall2"}, cpu_stall, 1);
        step();
        bus_gnt = 1'b0;
        #1;
        check_val({tag, "_done"},  cpu_done, 1);
        check_val({tag, "_stall3"}, cpu_stall, 0);
        check_val({tag, "_err"},   mem_err, 0);
        check_val({tag, "_reqoff"}, bus_req, 0);
        cpu_store = 1'b0;
        step();
        check_val({tag, "_done_once"}, cpu_done, 0);
    endtask

    // IDLE -> REQ -> WAIT [-> WAIT] -> DONE; early_rv drives a bogus rvalid alongside gnt
    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] rd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_rd,
                            input bit early_rv);
        cpu_load = 1'b1; cpu_addr = a; cpu_funct3 = f3;
        #1;
        check_val({tag, "_stall1"}, cpu_stall, 1);
        step();
        bus_gnt = 1'b1;
        if (early_rv) begin
            bus_rvalid = 1'b1;
            bus_rdata  = ~rd;
        end
        #1;
        check_val({tag, "_req"},  bus_req, 1);
        check_val({tag, "_we"},   bus_we, 0);
        check_val({tag, "_addr"}, bus_addr, exp_addr);
        check_val({tag, "_be"},   bus_be, exp_be);
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        if (early_rv) begin
            #1;
            check_val({tag, "_early_ignored"}, cpu_done, 0);
            step();
        end
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        #1;
        check_val({tag, "_reqoff"}, bus_req, 0);
        check_val({tag, "_notdone"}, cpu_done, 0);
        check_val({tag, "_stall3"}, cpu_stall, 1);
        step();
        bus_rvalid = 1'b0;
        #1;
        check_val({tag, "_done"},  cpu_done, 1);
        check_val({tag, "_rdata"}, cpu_rdata, exp_rd);
        check_val({tag, "_err"},   mem_err, 0);
        check_val({tag, "_stall4"}, cpu_stall, 0);
        cpu_load = 1'b0;
        step();
    endtask

    // Access rejected in IDLE: straight to DONE with an error and no bus request
    task automatic run_err(input string tag, input bit st, input logic [31:0] a,
                           input logic [2:0] f3, input logic [31:0] exp_rd);
        cpu_load = !st; cpu_store = st; cpu_addr = a; cpu_funct3 = f3; cpu_wdata = 32'h5555_AAAA;
        #1;
        check_val({tag, "_noreq1"}, bus_req, 0);
        step();
        check_val({tag, "_done"},  cpu_done, 1);
        check_val({tag, "_err"},   mem_err, 1);
        check_val({tag, "_noreq2"}, bus_req, 0);
        check_val({tag, "_rdata"}, cpu_rdata, exp_rd);
        cpu_load = 1'b0; cpu_store = 1'b0;
        step();
        check_val({tag, "_idle"}, cpu_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_load = 0; cpu_store = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        step();
        step();
        check_val("rst_req",   bus_req, 0);
        check_val("rst_we",    bus_we, 0);
        check_val("rst_be",    bus_be, 0);
        check_val("rst_addr",  bus_addr, 0);
        check_val("rst_wdata", bus_wdata, 0);
        check_val("rst_rdata", cpu_rdata, 0);
        check_val("rst_done",  cpu_done, 0);
        check_val("rst_err",   mem_err, 0);
        reset = 1'b0;
        step();

        run_store("sb", 32'h0000_1003, 3'b000, 32'hABCD_12EF, 32'h0000_1000, 4'b1000, 32'hEFEF_EFEF);
        run_store("sh", 32'h0000_1002, 3'b001, 32'h1234_ABCD, 32'h0000_1000, 4'b1100, 32'hABCD_ABCD);
        run_store("sw", 32'h0000_1004, 3'b010, 32'hCAFE_BABE, 32'h0000_1004, 4'b1111, 32'hCAFE_BABE);

        run_load("lh",  32'h0000_2002, 3'b001, 32'h8001_7FFF, 32'h0000_2000, 4'b1100, 32'hFFFF_8001, 1'b0);
        run_load("lhu", 32'h0000_2002, 3'b101, 32'h8001_7FFF, 32'h0000_2000, 4'b1100, 32'h0000_8001, 1'b1);
        run_load("lbu", 32'h0000_2003, 3'b100, 32'h9A00_0000, 32'h0000_2000, 4'b1000, 32'h0000_009A, 1'b0);

        run_err("ill_ld", 1'b0, 32'h0000_0100, 3'b011, 32'h0000_009A);
        run_err("ill_st", 1'b1, 32'h0000_0100, 3'b100, 32'h0000_009A);

        // Grant never arrives: eight REQ cycles, then abort
        cpu_load = 1'b1; cpu_addr = 32'h0000_5000; cpu_funct3 = 3'b010;
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("to_req", bus_req, 1);
            step();
        end
        #1;
        check_val("to_done",  cpu_done, 1);
        check_val("to_err",   mem_err, 1);
        check_val("to_rdata", cpu_rdata, 0);
        check_val("to_reqoff", bus_req, 0);
        cpu_load = 1'b0;
        step();

`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
        run_err("mis_lw", 1'b0, 32'h0000_4001, 3'b010, 32'h0000_0000);
`else
        run_load("mis_lw", 32'h0000_4001, 3'b010, 32'hCAFE_F00D, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 1'b0);
`endif

        // Grant withheld for five REQ cycles; request must hold steady
        cpu_load = 1'b1; cpu_addr = 32'h0000_3000; cpu_funct3 = 3'b010;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("lw_hold_req",  bus_req, 1);
            check_val("lw_hold_addr", bus_addr, 32'h0000_3000);
            step();
        end
        bus_gnt = 1'b1;
        #1;
        check_val("lw_gnt_req", bus_req, 1);
        step();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        check_val("lw_reqoff", bus_req, 0);
        check_val("lw_notdone", cpu_done, 0);
        step();
        bus_rvalid = 1'b0;
        #1;
        check_val("lw_done",  cpu_done, 1);
        check_val("lw_rdata", cpu_rdata, 32'h1234_5678);
        cpu_load = 1'b0;
        step();
        check_val("lw_done_once", cpu_done, 0);

        // Reset while waiting for read data
        cpu_load = 1'b1; cpu_addr = 32'h0000_6000; cpu_funct3 = 3'b010;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        reset = 1'b1; cpu_load = 1'b0;
        #1;
        check_val("rw_req",   bus_req, 0);
        check_val("rw_addr",  bus_addr, 0);
        check_val("rw_be",    bus_be, 0);
        check_val("rw_rdata", cpu_rdata, 0);
        check_val("rw_done",  cpu_done, 0);
        check_val("rw_stall", cpu_stall, 0);
        step();
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        check_val("rw_late_done", cpu_done, 0);
        step();
        bus_rvalid = 1'b0;
        #1;
        check_val("rw_late_rdata", cpu_rdata, 0);
        check_val("rw_late_done2", cpu_done, 0);
        step();

        run_load("lb_post", 32'h0000_7001, 3'b000, 32'h0000_8500, 32'h0000_7000, 4'b0010, 32'hFFFF_FF85, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store stage directly downstream of the core datapath.
- Consumes the ALU-computed address, rs2 store data, funct3 and the load/store strobes.
- Runs a req/gnt/rvalid handshake to the data memory bus, builds byte enables and lane-shifts store data.
- Sign- or zero-extends load data back to the core and stalls the core until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum cycles spent in REQ plus WAIT before the access is aborted with an error.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_load  in  1  load request (level, held while stalled).
- cpu_store  in  1  store request (level, held while stalled).
- cpu_addr  in  ADDR_W  byte address from the ALU.
- cpu_wdata  in  32  raw rs2 value, unshifted.
- cpu_funct3  in  3  access width and sign (instruction bits 14:12).
- cpu_rdata  out  32  extended load result.
- cpu_stall  out  1  freezes the PC and register write.
- cpu_done  out  1  one-cycle completion pulse.
- mem_err  out  1  error flag, valid with cpu_done.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address; low 2 bits are 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async, immediate) clears:
  - state to IDLE;
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata to 0;
  - cpu_rdata to 0, cpu_done to 0, mem_err to 0;
  - timeout counter to 0.
- Reset mid-access drops bus_req at once. A late bus_rvalid is ignored.
- IDLE, with cpu_load or cpu_store high:
  - latch addr, funct3, wdata and direction, then go to REQ;
  - store wins if both strobes are high.
- Illegal funct3 (load 011/110/111; store other than 000/001/010) → DONE with mem_err=1 and no bus access.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0): handling depends on MISALIGN_TRAP_EN (see Optional Feature).
- REQ:
  - bus_req=1, with addr/be/we/wdata stable until bus_gnt is sampled high;
  - on gnt: store → DONE, load → WAIT;
  - bus_req deasserts the cycle after gnt.
- WAIT: on bus_rvalid, register the extended rdata and go to DONE. bus_rvalid in the same cycle as gnt is not accepted; data comes earliest the cycle after gnt.
- Byte enables:
  - byte: 0001 << addr[1:0];
  - half: 0011 << {addr[1],0};
  - word: 1111.
- Store data replicated per lane:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}}.
- Load extraction:
  - select the byte or half by addr low bits;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Timeout:
  - the counter increments every cycle in REQ or WAIT;
  - reaching TIMEOUT → DONE with mem_err=1, cpu_rdata=0, bus_req dropped.
- DONE:
  - cpu_done=1 for exactly one cycle, cpu_stall=0, then IDLE;
  - cpu_rdata holds until the next load completes.
- cpu_stall (combinational) = (cpu_load|cpu_store) && state≠DONE. This includes the IDLE cycle where the request is first seen.
- Latency:
  - store with immediate gnt: 3 cycles (IDLE, REQ, DONE);
  - load with gnt then rvalid next cycle: 4 cycles.
- Back-to-back accesses: after DONE, IDLE accepts the next request the following cycle. There is no pipelining.

Optional Feature:
- Macro: DATA_MEM_CTRL_MISALIGN_TRAP_EN.
- Defined:
  - misaligned access goes IDLE→DONE with mem_err=1 and no bus activity;
  - cpu_rdata is unchanged.
- Undefined:
  - the address is silently force-aligned (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally;
  - mem_err is never set for misalignment.

Decomposition:
- Shared package (mem_pkg):
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - FSM state encoding typedef;
  - BE_BYTE/BE_HALF/BE_WORD base masks.
- One sub-module: mem_lane_align, purely combinational.
  - Computes be and shifted wdata from addr/funct3/wdata.
  - Extracts and extends rdata.
  - Reused later by the instruction-side fetch path.

Test Plan:
- SB: addr=0x1003, wdata=0xABCD12EF, gnt on 1st REQ cycle → bus_addr=0x1000, be=1000, bus_wdata=0xEFEFEFEF, bus_we=1; cpu_done pulses in cycle 3; stall high cycles 1–2.
- LH at 0x2002, rdata=0x8001_7FFF, gnt then rvalid next cycle → cpu_rdata=0xFFFF8001. LHU at the same address gives 0x00008001. Done at cycle 4.
- LW 0x3000, gnt withheld 5 cycles → bus_req and bus_addr stable for all 5 cycles; single bus_req pulse train; done one cycle after rvalid. Data 0x12345678 is passed through.
- LW with gnt never asserted (TIMEOUT=8) → after 8 cycles in REQ, mem_err=1, cpu_rdata=0, bus_req=0, done pulse.
- LW at 0x4001 → with the macro: done with mem_err=1 and no bus_req ever. Without it: bus_addr=0x4000, be=1111, mem_err=0.
- Reset asserted in WAIT, then rvalid → all outputs 0 immediately; the late rvalid is ignored; a new LB after reset behaves normally.
